// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_unit
//  Brief    : Sequential ALU. Shifts take one bit-step per cycle. The optional
//             shift-add multiplier is enabled by defining ALU_SEQ_MUL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [1:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int                 c_CNT_W   = SHW + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_SLT = 4'd7,
        OP_MUL = 4'd8
    } op_t;

    state_t               r_state, w_next_state;
    op_t                  r_op, w_dec_op;
    logic [WIDTH-1:0]     r_a, r_result;
    logic                 r_zero;
    logic [c_CNT_W-1:0]   r_cnt, w_init_cnt;
    logic [5:0]           r_funct;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_quick, w_step_a, w_exec_val;
    logic                 w_accept, w_long, w_is_shift;
    logic                 w_unused_funct;

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]     r_b, r_acc, w_step_acc;
`endif

    assign w_shamt        = b[SHW-1:0];
    assign w_accept       = in_valid && in_ready;
    assign w_unused_funct = ^r_funct;
    assign result         = r_result;
    assign zero           = r_zero;

    always_comb begin
        w_dec_op = OP_ADD;
        case (aluop)
            2'd1: w_dec_op = OP_SUB;
            2'd2: begin
                case (opcode)
                    6'b000001:            w_dec_op = OP_SUB;
                    6'b010000, 6'b010001: w_dec_op = OP_AND;
                    6'b010010, 6'b010011: w_dec_op = OP_OR;
                    6'b011000:            w_dec_op = OP_SLL;
                    6'b011001:            w_dec_op = OP_SRL;
                    6'b011010:            w_dec_op = OP_SRA;
                    6'b011100:            w_dec_op = OP_SLT;
`ifdef ALU_SEQ_MUL_EN
                    6'b100000:            w_dec_op = OP_MUL;
`endif
                    default:              w_dec_op = OP_ADD;
                endcase
            end
            default: w_dec_op = OP_ADD;
        endcase
    end

    // Single-cycle result; a zero-count shift simply passes operand A through.
    always_comb begin
        w_quick    = a + b;
        w_is_shift = (w_dec_op == OP_SLL) || (w_dec_op == OP_SRL) || (w_dec_op == OP_SRA);
        case (w_dec_op)
            OP_SUB:                 w_quick = a - b;
            OP_AND:                 w_quick = a & b;
            OP_OR:                  w_quick = a | b;
            OP_SLT:                 w_quick = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL, OP_SRL, OP_SRA: w_quick = a;
            default:                w_quick = a + b;
        endcase
        w_long     = (w_is_shift && (w_shamt != '0)) || (w_dec_op == OP_MUL);
        w_init_cnt = (w_dec_op == OP_MUL) ? c_CNT_W'(WIDTH) : {1'b0, w_shamt};
    end

    always_comb begin
        case (r_op)
            OP_SLL, OP_MUL: w_step_a = r_a << 1;
            OP_SRL:         w_step_a = r_a >> 1;
            OP_SRA:         w_step_a = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            default:        w_step_a = r_a;
        endcase
`ifdef ALU_SEQ_MUL_EN
        w_step_acc = r_acc + (r_b[0] ? r_a : '0);
        w_exec_val = (r_op == OP_MUL) ? w_step_acc : w_step_a;
`else
        w_exec_val = w_step_a;
`endif
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = w_long ? ST_EXEC : ST_DONE;
            end
            ST_EXEC: if (r_cnt == c_CNT_ONE) w_next_state = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_cnt    <= '0;
            r_funct  <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            r_b      <= '0;
            r_acc    <= '0;
`endif
        end else if (w_accept) begin
            r_op    <= w_dec_op;
            r_a     <= a;
            r_funct <= funct;
            r_cnt   <= w_long ? w_init_cnt : '0;
`ifdef ALU_SEQ_MUL_EN
            r_b     <= b;
            r_acc   <= '0;
`endif
            if (!w_long) begin
                r_result <= w_quick;
                r_zero   <= (w_quick == '0);
            end
        end else if (r_state == ST_EXEC) begin
            r_a   <= w_step_a;
            r_cnt <= r_cnt - c_CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
            r_b   <= r_b >> 1;
            r_acc <= w_step_acc;
`endif
            if (r_cnt == c_CNT_ONE) begin
                r_result <= w_exec_val;
                r_zero   <= (w_exec_val == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-count width; derived, not overridden.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 opcode  input  6  instruction opcode.
REQ-008 funct  input  6  instruction funct field; captured, unused by decode.
REQ-009 aluop  input  2  main-control ALU class.
REQ-010 a  input  WIDTH  operand A.
REQ-011 b  input  WIDTH  operand B; b[SHW-1:0] is the shift count for shifts.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes result.
REQ-014 result  output  WIDTH  registered result.
REQ-015 zero  output  1  registered (result == 0).

Function
REQ-016 Decode at accept: aluop 0 or 3 -> add; aluop 1 -> sub; aluop 2 -> opcode table.
REQ-017 Opcode table: 000000 add, 000001 sub, 000010 add, 010000/010001 and, 010010/010011 or, 011000 sll, 011001 srl, 011010 sra, 011100 slt (signed, result 1 or 0), 100000 mul; any other -> add.
REQ-018 Add/sub/mul wrap modulo 2^WIDTH; mul result is the low WIDTH bits of the product.
REQ-019 FSM states IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-020 Accept = in_valid && in_ready; operands, decoded op, and shift count latched on accept.
REQ-021 Add/sub/and/or/slt: IDLE -> DONE; out_valid asserted the cycle after accept (latency 1).
REQ-022 Shift with count k > 0: IDLE -> EXEC; one-bit shift per cycle; EXEC -> DONE after k steps; out_valid at accept+1+k.
REQ-023 Shift with k = 0: IDLE -> DONE with result = a; latency 1.
REQ-024 sra replicates a[WIDTH-1]; srl and sll shift in zeros.
REQ-025 Mul: shift-add in EXEC, one multiplier bit per cycle, WIDTH steps; out_valid at accept+1+WIDTH.
REQ-026 DONE: result and zero held stable while out_valid=1 and out_ready=0.
REQ-027 DONE with out_ready=1 -> IDLE next cycle; no request accepted in that same cycle.
REQ-028 Input changes outside the accept cycle have no effect on an operation in progress.
REQ-029 out_valid is 1 only in DONE; result/zero change only on DONE entry or reset.

Reset
REQ-030 rst_n low, at any time including mid-EXEC or DONE: state IDLE, out_valid 0, result 0, zero 1, step counter 0; in-flight operation discarded.
REQ-031 First accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro ALU_SEQ_MUL_EN defined: opcode 100000 decodes as mul per REQ-017/025.
REQ-033 Macro ALU_SEQ_MUL_EN undefined: multiply datapath absent; opcode 100000 decodes as add, latency 1.

Verification
REQ-034 Reset mid-mul (assert rst_n=0 at EXEC cycle 5) -> out_valid 0, result 0, zero 1, in_ready 1 after release.
REQ-035 aluop=2, opcode=000001, a=5, b=7 -> out_valid one cycle after accept, result 0xFFFFFFFE, zero 0.
REQ-036 aluop=2, opcode=011010, a=0x80000000, b=4 -> out_valid at accept+5, result 0xF8000000; with b=0 -> accept+1, result 0x80000000.
REQ-037 aluop=2, opcode=100000, a=0x10000, b=0x10000, macro defined -> out_valid at accept+33, result 0, zero 1; macro undefined -> accept+1, result 0x20000.
REQ-038 slt a=0xFFFFFFFF, b=1 -> result 1; hold out_ready=0 for 10 cycles -> result stable, in_ready 0; out_ready=1 -> IDLE next cycle, in_ready 1.
